// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM states and byte-lane helpers shared by the
// RV32I load/store unit and its load alignment block.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2
  } lsu_state_e;

  // Stores only have the signed encodings; the unsigned ones are load-only.
  function automatic logic is_legal(input logic store, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // size is funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      2'b01:   ok = !off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] strb;
    case (size)
      2'b00:   strb = 4'b0001 << off;
      2'b01:   strb = 4'b0011 << off;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Replicating the datum across lanes lets the strobe alone pick the bytes.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      2'b00:   lanes = {4{data[7:0]}};
      2'b01:   lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

  // Input is the read word already shifted so the addressed byte sits in [7:0].
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] s);
    logic [31:0] r;
    case (f3)
      F3_B:    r = {{24{s[7]}}, s[7:0]};
      F3_H:    r = {{16{s[15]}}, s[15:0]};
      F3_BU:   r = {24'h0, s[7:0]};
      F3_HU:   r = {16'h0, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: moves the addressed byte/half of a read word down to bit 0
// and sign- or zero-extends it according to the load's funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_word >> {i_off, 3'b000};
  assign o_data    = load_extend(i_funct3, w_shifted);

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: runs one RV32I load or store at a time over a req/ack data
// memory port and writes aligned load data back through the regfile port.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        RegWrite,
  output logic [4:0]  waddr,
  output logic [31:0] wdata
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  lsu_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we, r_req, r_done, r_err, r_regwrite;
  logic [31:0]      r_addr, r_mwdata, r_wdata;
  logic [3:0]       r_strb;
  logic [4:0]       r_rd;
  logic [2:0]       r_funct3;

  logic [31:0] w_addr, w_load_data;
  logic        w_legal, w_aligned, w_at_limit;
  logic        w_accept, w_reject, w_complete, w_timeout;

  assign w_addr     = base + offset;
  assign w_legal    = is_legal(is_store, funct3);
  assign w_aligned  = is_aligned(funct3[1:0], w_addr[1:0]);
  assign w_at_limit = (TIMEOUT != 0) && (r_cnt == LP_CNT_LAST);

  lsu_load_align u_align (
    .i_word   (mem_rdata),
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_data   (w_load_data)
  );

  // State register; reset abandons any request in flight.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus the one-cycle events that steer the datapath registers.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_legal && w_aligned) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_REQ;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          w_complete  = 1'b1;
          w_state_nxt = r_we ? ST_IDLE : ST_WB;
        end else if (w_at_limit) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WB:   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latched request, flop-driven status pulses, wait counter and load result.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_req      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_regwrite <= 1'b0;
      r_addr     <= '0;
      r_mwdata   <= '0;
      r_wdata    <= '0;
      r_strb     <= '0;
      r_rd       <= '0;
      r_funct3   <= '0;
    end else begin
      r_done     <= w_complete;
      r_err      <= w_reject || w_timeout;
      r_regwrite <= w_complete && !r_we && (r_rd != 5'd0);
      if (w_accept) begin
        r_req    <= 1'b1;
        r_we     <= is_store;
        r_addr   <= w_addr;
        r_mwdata <= is_store ? store_lanes(funct3[1:0], store_data) : 32'h0;
        r_strb   <= is_store ? store_strb(funct3[1:0], w_addr[1:0]) : 4'b0000;
        r_rd     <= rd;
        r_funct3 <= funct3;
      end else if (w_complete || w_timeout) begin
        r_req <= 1'b0;
      end
      if (w_complete && !r_we) r_wdata <= w_load_data;
      if (r_state == ST_REQ && !mem_ack && !w_at_limit) r_cnt <= r_cnt + 1'b1;
      else                                              r_cnt <= '0;
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_mwdata;
  assign mem_wstrb = r_strb;
  assign RegWrite  = r_regwrite;
  assign waddr     = r_rd;
  assign wdata     = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for the load/store unit with a
// 4-cycle memory timeout and a behavioural memory responder.
module tb_load_store_unit;

  logic        Clk = 1'b0;
  logic        Rst, start, is_store;
  logic [2:0]  funct3;
  logic [31:0] base, offset, store_data;
  logic [4:0]  rd;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        RegWrite;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } mem_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  mem_t expMem[$], obsMem[$];
  wb_t  expWb[$],  obsWb[$];

  int total = 0, bad = 0;
  int cyc = 0, stCyc = 0, rwCyc = -1, doneCyc = -1;
  int nReq = 0, nRw = 0, nDone = 0, nErr = 0, nBusy = 0;

  always #5 Clk = ~Clk;

  load_store_unit #(.TIMEOUT(4), .CNT_W(3)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .is_store(is_store), .funct3(funct3),
    .base(base), .offset(offset), .store_data(store_data), .rd(rd),
    .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .RegWrite(RegWrite), .waddr(waddr), .wdata(wdata)
  );

  // Free-running cycle number, used to measure latencies.
  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor on the falling edge: record handshakes, writebacks and pulse counts.
  always @(negedge Clk) begin
    if (mem_req) nReq++;
    if (busy) nBusy++;
    if (err) nErr++;
    if (done) begin nDone++; doneCyc = cyc; end
    if (mem_req && mem_ack)
      obsMem.push_back({mem_we, mem_addr, (mem_we ? mem_wdata : 32'h0), mem_wstrb});
    if (RegWrite) begin
      nRw++;
      rwCyc = cyc;
      obsWb.push_back({waddr, wdata});
    end
  end

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
    logic [7:0]  b [4];
    logic [15:0] h;
    logic [31:0] r;
    for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
    h = {b[a | 2'd1], b[a]};
    case (f3)
      3'b000:  r = {{24{b[a][7]}}, b[a]};
      3'b100:  r = {24'h0, b[a]};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [35:0] modelStore(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] sd);
    logic [31:0] d;
    logic [3:0]  s;
    for (int k = 0; k < 4; k++) begin
      case (f3[1:0])
        2'b00: begin s[k] = (k == int'(a));       d[8*k +: 8] = sd[7:0]; end
        2'b01: begin s[k] = ((k / 2) == int'(a) / 2); d[8*k +: 8] = sd[8*(k % 2) +: 8]; end
        default: begin s[k] = 1'b1;               d[8*k +: 8] = sd[8*k +: 8]; end
      endcase
    end
    return {d, s};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clearCounters();
    nReq = 0; nRw = 0; nDone = 0; nErr = 0; nBusy = 0;
    rwCyc = -1; doneCyc = -1;
  endtask

  // One-cycle start pulse, then act as memory: ack after 'waits' request cycles.
  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] b,
                               input logic [31:0] o, input logic [31:0] sd,
                               input logic [31:0] rdv, input logic [4:0] r, input int waits);
    int n;
    clearCounters();
    start = 1'b1; is_store = st; funct3 = f3; base = b; offset = o;
    store_data = sd; rd = r;
    stCyc = cyc;
    tick();
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 30 && busy; c++) begin
      if (mem_req) begin
        if (n == waits) begin mem_ack = 1'b1; mem_rdata = rdv; end
        n++;
      end
      tick();
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hang: busy=%0b required=0 after cycle budget", busy);
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick();
    tick();
    total++;
    if ({busy, done, err, mem_req, mem_we, RegWrite} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got=%b want=000000",
               {busy, done, err, mem_req, mem_we, RegWrite});
    end
    total++;
    if ({mem_addr, mem_wdata, mem_wstrb, waddr, wdata} !== 105'h0) begin
      bad++;
      $display("[TB] FAIL reset_data: got addr=%h mwdata=%h strb=%b waddr=%0d wdata=%h want all 0",
               mem_addr, mem_wdata, mem_wstrb, waddr, wdata);
    end
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    mem_t e, o;
    wb_t  ew, ow;
    expMem.push_back({1'b0, 32'h104, 32'h0, 4'b0000});
    expWb.push_back({5'd5, 32'hDEADBEEF});
    applyStimulus(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 32'hDEADBEEF, 5'd5, 3);
    total++;
    if (nReq !== 4 || obsMem.size() != 1) begin
      bad++;
      $display("[TB] FAIL lw_req: got cycles=%0d handshakes=%0d want 4 and 1", nReq, obsMem.size());
    end
    e = expMem.pop_front();
    total++;
    if (obsMem.size() == 0) begin
      bad++;
      $display("[TB] FAIL lw_mem: got no handshake want %h", e);
    end else begin
      o = obsMem.pop_front();
      if (o !== e) begin bad++; $display("[TB] FAIL lw_mem: got=%h want=%h", o, e); end
    end
    ew = expWb.pop_front();
    total++;
    if (obsWb.size() == 0) begin
      bad++;
      $display("[TB] FAIL lw_wb: got no writeback want %h", ew);
    end else begin
      ow = obsWb.pop_front();
      if (ow !== ew) begin bad++; $display("[TB] FAIL lw_wb: got=%h want=%h", ow, ew); end
    end
    total++;
    if (nRw !== 1 || nDone !== 1 || rwCyc !== stCyc + 5 || doneCyc !== stCyc + 5) begin
      bad++;
      $display("[TB] FAIL lw_timing: got rw=%0d done=%0d rwAt=%0d doneAt=%0d want 1 1 %0d %0d",
               nRw, nDone, rwCyc - stCyc, doneCyc - stCyc, 5, 5);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] offs[5] = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd1};
    logic [31:0] rdvs[5] = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h0000_7F00};
    logic [31:0] exps[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h0000_007F};
    wb_t ew, ow;
    for (int i = 0; i < 5; i++) begin
      expWb.push_back({5'(i + 1), exps[i]});
      applyStimulus(1'b0, f3s[i], 32'h100, offs[i], 32'h0, rdvs[i], 5'(i + 1), 0);
      obsMem.delete();
      ew = expWb.pop_front();
      total++;
      if (obsWb.size() == 0) begin
        bad++;
        $display("[TB] FAIL load_ext%0d: got no writeback want %h", i, ew);
      end else begin
        ow = obsWb.pop_front();
        if (ow !== ew) begin bad++; $display("[TB] FAIL load_ext%0d: got=%h want=%h", i, ow, ew); end
      end
      total++;
      if (rwCyc !== stCyc + 2) begin
        bad++;
        $display("[TB] FAIL load_lat%0d: got=%0d want=2", i, rwCyc - stCyc);
      end
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3s [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] offs[3] = '{32'h201, 32'h202, 32'h204};
    logic [31:0] exd [3] = '{32'h7878_7878, 32'h5678_5678, 32'h1234_5678};
    logic [3:0]  exs [3] = '{4'b0010, 4'b1100, 4'b1111};
    mem_t e, o;
    for (int i = 0; i < 3; i++) begin
      expMem.push_back({1'b1, offs[i], exd[i], exs[i]});
      applyStimulus(1'b1, f3s[i], 32'h0, offs[i], 32'h1234_5678, 32'h0, 5'd3, i);
      e = expMem.pop_front();
      total++;
      if (obsMem.size() == 0) begin
        bad++;
        $display("[TB] FAIL store%0d: got no handshake want %h", i, e);
      end else begin
        o = obsMem.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL store%0d: got=%h want=%h", i, o, e); end
      end
      total++;
      if (nRw !== 0 || nDone !== 1 || doneCyc !== stCyc + 2 + i) begin
        bad++;
        $display("[TB] FAIL store_done%0d: got rw=%0d done=%0d at=%0d want 0 1 %0d",
                 i, nRw, nDone, doneCyc - stCyc, 2 + i);
      end
      obsWb.delete();
    end
  endtask

  task automatic test_errors();
    logic        sts [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [4] = '{3'b010, 3'b011, 3'b100, 3'b001};
    logic [31:0] offs[4] = '{32'd2, 32'd0, 32'd0, 32'd1};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(sts[i], f3s[i], 32'h100, offs[i], 32'h0, 32'h0, 5'd4, 0);
      total++;
      if (nErr !== 1 || nReq !== 0 || nBusy !== 0 || nDone !== 0 || obsMem.size() != 0) begin
        bad++;
        $display("[TB] FAIL error%0d: got err=%0d req=%0d busy=%0d done=%0d hs=%0d want 1 0 0 0 0",
                 i, nErr, nReq, nBusy, nDone, obsMem.size());
      end
      obsMem.delete();
    end
  endtask

  task automatic test_timeout();
    applyStimulus(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 32'h1111_1111, 5'd9, 99);
    total++;
    if (nReq !== 4 || nErr !== 1 || nRw !== 0 || nDone !== 0) begin
      bad++;
      $display("[TB] FAIL timeout: got req=%0d err=%0d rw=%0d done=%0d want 4 1 0 0",
               nReq, nErr, nRw, nDone);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h2222_2222;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    total++;
    if (nRw !== 0 || nDone !== 0 || nErr !== 1 || busy !== 1'b0 || obsMem.size() != 0) begin
      bad++;
      $display("[TB] FAIL late_ack: got rw=%0d done=%0d err=%0d busy=%0b hs=%0d want 0 0 1 0 0",
               nRw, nDone, nErr, busy, obsMem.size());
    end
  endtask

  task automatic test_reset_mid();
    clearCounters();
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; base = 32'h400; offset = 32'h0; rd = 5'd7;
    tick();
    start = 1'b0;
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("[TB] FAIL mid_req: got=%0b want=1", mem_req); end
    #2 Rst = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset: got req=%0b busy=%0b want 0 0", mem_req, busy);
    end
    tick();
    Rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    total++;
    if (nRw !== 0 || nDone !== 0 || obsWb.size() != 0) begin
      bad++;
      $display("[TB] FAIL mid_late_ack: got rw=%0d done=%0d wb=%0d want 0 0 0", nRw, nDone, obsWb.size());
    end
  endtask

  task automatic test_rd0();
    mem_t e, o;
    expMem.push_back({1'b0, 32'h508, 32'h0, 4'b0000});
    applyStimulus(1'b0, 3'b010, 32'h500, 32'h8, 32'h0, 32'h0BAD_CAFE, 5'd0, 1);
    total++;
    if (nDone !== 1 || nRw !== 0) begin
      bad++;
      $display("[TB] FAIL rd0: got done=%0d rw=%0d want 1 0", nDone, nRw);
    end
    e = expMem.pop_front();
    total++;
    if (obsMem.size() == 0) begin
      bad++;
      $display("[TB] FAIL rd0_mem: got no handshake want %h", e);
    end else begin
      o = obsMem.pop_front();
      if (o !== e) begin bad++; $display("[TB] FAIL rd0_mem: got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic        st;
    logic [2:0]  f3;
    logic [1:0]  a;
    logic [31:0] b, sd, rdv;
    logic [4:0]  r;
    logic [35:0] ds;
    mem_t e, o;
    wb_t  ew, ow;
    for (int i = 0; i < 10; i++) begin
      st  = 1'($urandom_range(0, 1));
      f3  = st ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)];
      a   = (f3[1:0] == 2'b00) ? 2'($urandom_range(0, 3)) :
            (f3[1:0] == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      b   = 32'h1000 + 32'($urandom_range(0, 63) * 4);
      sd  = $urandom;
      rdv = $urandom;
      r   = 5'($urandom_range(1, 31));
      if (st) begin
        ds = modelStore(f3, a, sd);
        expMem.push_back({1'b1, b + 32'(a), ds[35:4], ds[3:0]});
      end else begin
        expMem.push_back({1'b0, b + 32'(a), 32'h0, 4'b0000});
        expWb.push_back({r, modelLoad(f3, a, rdv)});
      end
      applyStimulus(st, f3, b, 32'(a), sd, rdv, r, int'($urandom_range(0, 2)));
    end
    total++;
    if (obsMem.size() != expMem.size() || obsWb.size() != expWb.size()) begin
      bad++;
      $display("[TB] FAIL b2b_count: got hs=%0d wb=%0d want %0d %0d",
               obsMem.size(), obsWb.size(), expMem.size(), expWb.size());
    end
    while (expMem.size() != 0 && obsMem.size() != 0) begin
      e = expMem.pop_front();
      o = obsMem.pop_front();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL b2b_mem: got=%h want=%h", o, e); end
    end
    while (expWb.size() != 0 && obsWb.size() != 0) begin
      ew = expWb.pop_front();
      ow = obsWb.pop_front();
      total++;
      if (ow !== ew) begin bad++; $display("[TB] FAIL b2b_wb: got=%h want=%h", ow, ew); end
    end
  endtask

  initial begin
    Rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    base = 32'h0; offset = 32'h0; store_data = 32'h0; rd = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_rd0();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
